// File: rtl/ysyx_24080006_issue_ctrl_if.sv
// ID/EX/WB handshake bundle for the issue controller.
// The perf counter outputs exist only when YSYX_24080006_ISSUE_PERF_EN is defined.
interface ysyx_24080006_issue_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_en;
  logic        id_rs2_en;
  logic [4:0]  id_rd;
  logic        id_wb;
  logic        id_serial;
  logic        ex_ready;
  logic        id_ready;
  logic        id_issue;
  logic        ex_redirect;
  logic [31:0] ex_dnpc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [2:0]  inflight;
  logic        busy;
`ifdef YSYX_24080006_ISSUE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_cnt;
`endif

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_wb, id_serial,
    input  ex_ready, ex_redirect, ex_dnpc, wb_valid, wb_en, wb_rd,
    output id_ready, id_issue, redirect_valid, redirect_pc, flush_ifid, inflight, busy
`ifdef YSYX_24080006_ISSUE_PERF_EN
    , output perf_stall_cycles, perf_flush_cnt
`endif
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_wb, id_serial,
    output ex_ready, ex_redirect, ex_dnpc, wb_valid, wb_en, wb_rd,
    input  id_ready, id_issue, redirect_valid, redirect_pc, flush_ifid, inflight, busy
`ifdef YSYX_24080006_ISSUE_PERF_EN
    , input perf_stall_cycles, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/ysyx_24080006_issue_ctrl.sv
// Issue/hazard controller: RAW scoreboard, CSR/ecall serialization, redirect/flush sequencing.
// Optional perf counters under YSYX_24080006_ISSUE_PERF_EN.
//
// state       | meaning
// RUN         | normal issue, gated by scoreboard hazards
// SERIAL_WAIT | serial instr in ID, draining older instructions
// SERIAL_POST | serial instr issued, blocking younger ones until it retires
// FLUSH       | one-cycle redirect pulse, IF/ID squashed
module ysyx_24080006_issue_ctrl #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  ysyx_24080006_issue_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN         = 2'd0,
    S_SERIAL_WAIT = 2'd1,
    S_SERIAL_POST = 2'd2,
    S_FLUSH       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [2:0]       INF_MAX = 3'(MAX_INFLIGHT);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt [32];
  logic [2:0]       r_inflight;
  logic [31:0]      r_redirect_pc;
  logic             w_hazard;
  logic             w_ready;
  logic             w_issue;
  logic             w_inc;
  logic             w_dec;

  // Only registered scoreboard state is used: a retire clears the hazard one cycle later.
  always_comb begin
    w_hazard = (bus.id_rs1_en && (bus.id_rs1 != 5'd0) && (r_cnt[bus.id_rs1] != '0)) ||
               (bus.id_rs2_en && (bus.id_rs2 != 5'd0) && (r_cnt[bus.id_rs2] != '0)) ||
               (bus.id_wb && (bus.id_rd != 5'd0) && (r_cnt[bus.id_rd] == CNT_MAX)) ||
               (r_inflight == INF_MAX);
    w_ready  = reset_n && (r_state == S_RUN) && bus.ex_ready && !w_hazard &&
               !(bus.id_serial && (r_inflight != 3'd0));
    w_issue  = bus.id_valid && w_ready;
    w_inc    = w_issue && bus.id_wb && (bus.id_rd != 5'd0);
    w_dec    = bus.wb_valid && bus.wb_en && (bus.wb_rd != 5'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc && (bus.id_rd == 5'(i)) && !(w_dec && (bus.wb_rd == 5'(i))))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec && (bus.wb_rd == 5'(i)) && !(w_inc && (bus.id_rd == 5'(i))))
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 3'd0;
    end else if (w_issue && !bus.wb_valid) begin
      r_inflight <= r_inflight + 3'd1;
    end else if (!w_issue && bus.wb_valid) begin
      r_inflight <= r_inflight - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_redirect_pc <= 32'd0;
    end else begin
      r_state <= w_next;
      if (bus.ex_redirect) r_redirect_pc <= bus.ex_dnpc;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_issue && bus.id_serial)
          w_next = S_SERIAL_POST;
        else if (bus.id_valid && bus.id_serial && (r_inflight != 3'd0))
          w_next = S_SERIAL_WAIT;
      end
      S_SERIAL_WAIT: if (r_inflight == 3'd0) w_next = S_RUN;
      S_SERIAL_POST: if (r_inflight == 3'd0) w_next = S_RUN;
      S_FLUSH:       w_next = S_RUN;
      default:       w_next = S_RUN;
    endcase
    if (bus.ex_redirect) w_next = S_FLUSH;
  end

  assign bus.id_ready       = w_ready;
  assign bus.id_issue       = w_issue;
  assign bus.redirect_valid = (r_state == S_FLUSH);
  assign bus.flush_ifid     = (r_state == S_FLUSH);
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.inflight       = r_inflight;
  assign bus.busy           = (r_inflight != 3'd0);

`ifdef YSYX_24080006_ISSUE_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Every redirect counts as a FLUSH entry, including back-to-back ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (bus.id_valid && !w_ready && (r_state != S_FLUSH)) r_perf_stall <= r_perf_stall + 32'd1;
      if (bus.ex_redirect) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_flush_cnt    = r_perf_flush;
`endif

  a_cnt_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    w_dec |-> (r_cnt[bus.wb_rd] != '0));
  a_inflight_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    bus.wb_valid |-> (r_inflight != 3'd0));
  a_inflight_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    w_issue |-> (r_inflight < INF_MAX));

endmodule

// File: tb/tb_ysyx_24080006_issue_ctrl.sv
// Directed bench for the issue controller: RAW, x0, same-cycle inc/dec, serial, redirect, reset, limits.
module tb_ysyx_24080006_issue_ctrl;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  ysyx_24080006_issue_ctrl_if u_if ();

  ysyx_24080006_issue_ctrl #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic e1,
                          input logic [4:0] rs2, input logic e2,
                          input logic [4:0] rd, input logic wb, input logic ser);
    u_if.id_valid  = v;
    u_if.id_rs1    = rs1;
    u_if.id_rs1_en = e1;
    u_if.id_rs2    = rs2;
    u_if.id_rs2_en = e2;
    u_if.id_rd     = rd;
    u_if.id_wb     = wb;
    u_if.id_serial = ser;
  endtask

  task automatic drive_wb(input logic v, input logic en, input logic [4:0] rd);
    u_if.wb_valid = v;
    u_if.wb_en    = en;
    u_if.wb_rd    = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    u_if.ex_ready    = 1'b1;
    u_if.ex_redirect = 1'b0;
    u_if.ex_dnpc     = 32'd0;
    drive_wb(0, 0, 0);
    drive_id(1, 0, 0, 0, 0, 5, 1, 0);
    #2;
    chk("rst_ready", {31'd0, u_if.id_ready}, 0);
    chk("rst_issue", {31'd0, u_if.id_issue}, 0);
    chk("rst_rv", {31'd0, u_if.redirect_valid}, 0);
    chk("rst_flush", {31'd0, u_if.flush_ifid}, 0);
    chk("rst_pc", u_if.redirect_pc, 0);
    chk("rst_inflight", {29'd0, u_if.inflight}, 0);
    chk("rst_busy", {31'd0, u_if.busy}, 0);

    // RAW on x5
    tick(); reset_n = 1'b1; #1;
    chk("raw_first_ready", {31'd0, u_if.id_ready}, 1);
    chk("raw_first_issue", {31'd0, u_if.id_issue}, 1);
    tick();
    drive_id(1, 5, 1, 0, 0, 6, 1, 0); #1;
    chk("raw_inflight1", {29'd0, u_if.inflight}, 1);
    chk("raw_busy", {31'd0, u_if.busy}, 1);
    chk("raw_stall0", {31'd0, u_if.id_ready}, 0);
    tick(); #1;
    chk("raw_stall1", {31'd0, u_if.id_ready}, 0);
    drive_wb(1, 1, 5); #1;
    chk("raw_no_bypass", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(0, 0, 0); #1;
    chk("raw_inflight0", {29'd0, u_if.inflight}, 0);
    chk("raw_release_issue", {31'd0, u_if.id_issue}, 1);
    tick(); drive_id(0, 0, 0, 0, 0, 0, 0, 0); drive_wb(1, 1, 6);
    tick(); drive_wb(0, 0, 0); #1;
    chk("raw_drained", {29'd0, u_if.inflight}, 0);

    // x0 never counted
    drive_id(1, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("x0_write_ready", {31'd0, u_if.id_ready}, 1);
    tick();
    drive_id(1, 0, 1, 0, 1, 0, 1, 0); drive_wb(1, 1, 0); #1;
    chk("x0_read_ready", {31'd0, u_if.id_ready}, 1);
    tick(); drive_id(0, 0, 0, 0, 0, 0, 0, 0); drive_wb(0, 0, 0); #1;
    chk("x0_inc_dec", {29'd0, u_if.inflight}, 1);
    drive_wb(1, 1, 0);
    tick(); drive_wb(0, 0, 0); #1;
    chk("x0_drained", {29'd0, u_if.inflight}, 0);

    // same-cycle inc/dec on x7
    drive_id(1, 0, 0, 0, 0, 7, 1, 0); #1;
    tick();
    drive_wb(1, 1, 7); #1;
    chk("x7_issue_retire", {31'd0, u_if.id_issue}, 1);
    tick(); drive_wb(0, 0, 0); drive_id(1, 7, 1, 0, 0, 0, 0, 0); #1;
    chk("x7_inflight_same", {29'd0, u_if.inflight}, 1);
    chk("x7_cnt_still1", {31'd0, u_if.id_ready}, 0);
    drive_wb(1, 1, 7);
    tick(); drive_wb(0, 0, 0); #1;
    chk("x7_cnt_cleared", {31'd0, u_if.id_ready}, 1);
    tick(); drive_id(0, 0, 0, 0, 0, 0, 0, 0); drive_wb(1, 0, 0);
    tick(); drive_wb(0, 0, 0); #1;
    chk("x7_drained", {29'd0, u_if.inflight}, 0);

    // serialization
    drive_id(1, 0, 0, 0, 0, 8, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 9, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 10, 1, 1); #1;
    chk("ser_inflight2", {29'd0, u_if.inflight}, 2);
    chk("ser_block_run", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(1, 1, 8); #1;
    chk("ser_wait_block", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(1, 1, 9);
    tick(); drive_wb(0, 0, 0); #1;
    chk("ser_wait_inflight0", {29'd0, u_if.inflight}, 0);
    chk("ser_wait_drain", {31'd0, u_if.id_ready}, 0);
    tick(); #1;
    chk("ser_issue", {31'd0, u_if.id_issue}, 1);
    tick(); drive_id(1, 0, 0, 0, 0, 11, 1, 0); #1;
    chk("ser_post_block", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(1, 1, 10); #1;
    chk("ser_post_block2", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(0, 0, 0); #1;
    chk("ser_post_last", {31'd0, u_if.id_ready}, 0);
    tick(); #1;
    chk("ser_younger_issue", {31'd0, u_if.id_issue}, 1);
    tick(); drive_id(0, 0, 0, 0, 0, 0, 0, 0); drive_wb(1, 1, 11);
    tick(); drive_wb(0, 0, 0); #1;
    chk("ser_drained", {29'd0, u_if.inflight}, 0);

    // redirect
    u_if.ex_redirect = 1'b1; u_if.ex_dnpc = 32'h8000_0100;
    tick(); u_if.ex_redirect = 1'b0; drive_id(1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rd_valid", {31'd0, u_if.redirect_valid}, 1);
    chk("rd_flush", {31'd0, u_if.flush_ifid}, 1);
    chk("rd_pc", u_if.redirect_pc, 32'h8000_0100);
    chk("rd_ready", {31'd0, u_if.id_ready}, 0);
    tick(); drive_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rd_back_run_rv", {31'd0, u_if.redirect_valid}, 0);
    chk("rd_back_run_ready", {31'd0, u_if.id_ready}, 1);
    u_if.ex_redirect = 1'b1; u_if.ex_dnpc = 32'h8000_0200;
    tick(); u_if.ex_dnpc = 32'h8000_0300; #1;
    chk("rd_b2b_pc0", u_if.redirect_pc, 32'h8000_0200);
    tick(); u_if.ex_redirect = 1'b0; #1;
    chk("rd_b2b_rv", {31'd0, u_if.redirect_valid}, 1);
    chk("rd_b2b_pc1", u_if.redirect_pc, 32'h8000_0300);
    tick(); #1;
    chk("rd_b2b_done", {31'd0, u_if.flush_ifid}, 0);

    // reset with instructions in flight
    drive_id(1, 0, 0, 0, 0, 12, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 13, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 14, 1, 0); tick();
    drive_id(1, 0, 0, 0, 0, 0, 0, 1); tick(); #1;
    chk("pre_rst_inflight", {29'd0, u_if.inflight}, 3);
    reset_n = 1'b0; #1;
    chk("mid_rst_inflight", {29'd0, u_if.inflight}, 0);
    chk("mid_rst_busy", {31'd0, u_if.busy}, 0);
    chk("mid_rst_ready", {31'd0, u_if.id_ready}, 0);
    chk("mid_rst_pc", u_if.redirect_pc, 0);
    tick(); reset_n = 1'b1;
    drive_id(1, 12, 1, 13, 1, 15, 1, 0); #1;
    chk("rst_cnt_cleared", {31'd0, u_if.id_ready}, 1);
    tick(); #1;
    chk("cnt15_1_ready", {31'd0, u_if.id_ready}, 1);
    tick(); #1;
    chk("cnt15_2_ready", {31'd0, u_if.id_ready}, 1);
    tick(); #1;
    chk("cnt_max_block", {31'd0, u_if.id_ready}, 0);
    drive_id(1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("cnt_max_other", {31'd0, u_if.id_ready}, 1);
    tick(); #1;
    chk("inflight4", {29'd0, u_if.inflight}, 4);
    chk("inflight_max_block", {31'd0, u_if.id_ready}, 0);
    drive_wb(1, 1, 15); #1;
    chk("max_no_bypass", {31'd0, u_if.id_ready}, 0);
    tick(); drive_wb(0, 0, 0); drive_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("max_after_retire", {31'd0, u_if.id_ready}, 1);
    drive_wb(1, 1, 15); tick();
    drive_wb(1, 1, 15); tick();
    drive_wb(1, 0, 0); tick();
    drive_wb(0, 0, 0); #1;
    chk("final_inflight", {29'd0, u_if.inflight}, 0);
    chk("final_busy", {31'd0, u_if.busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
